dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the load/store stage's memory requests over a single-outstanding valid/ready request/response handshake. Holds a word-addressed 64-bit backing store with byte-lane write masks and a programmable response latency. It lets the pipeline drop its DPI memory calls for a cycle-accurate RTL memory. Sits between the LS stage (initiator) and, later, the D-cache refill path.

## Interface
- XLEN, 64, data/address width
- DEPTH_WORDS, 1024, number of 64-bit words (power of two)
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- LATENCY, 2, extra wait cycles between request accept and response (0..15)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  XLEN  byte address; bits [2:0] ignored for word selection
- req_wdata  in  XLEN  store data, already placed in its byte lanes
- req_wmask  in  8  byte-lane enables of the aligned doubleword (stores only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  XLEN  full aligned doubleword (loads); 0 for stores and errors
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*8)

## Operation
- FSM states IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid & req_ready: latch wen, word index = (req_addr - BASE_ADDR) >> 3, wdata, wmask, error flag; load counter with LATENCY; go WAIT if LATENCY>0 else RESP.
- WAIT: req_ready=0; counter decrements each cycle; at counter==1 go RESP.
- Transition into RESP performs the access on that edge: store writes enabled lanes (no write if error or wmask==0); load captures word into rsp_rdata.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready; on rsp_valid & rsp_ready go IDLE. req_ready=0.
- Error: no array write, rsp_rdata=0, rsp_err=1; response still issued with normal latency.
- Store response: rsp_rdata=0, rsp_err per range check.
- Address wrap: subtraction is XLEN-bit unsigned; addr < BASE_ADDR fails the range check (no wrap into array).
- Load immediately after store to same word returns post-store data (store committed before its response).

## Timing
- Reset values: req_ready=0 while rst_n low, 1 from first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0; state IDLE, counter 0.
- Request handshake in cycle c -> rsp_valid first high in cycle c+1+LATENCY.
- Minimum request spacing: LATENCY+2 cycles (no accept in the response-handshake cycle).
- rsp_valid never drops without rsp_ready; rsp_ready stall of any length permitted.
- Reset asserted mid-WAIT/RESP: pending request discarded, any not-yet-committed store is not written; array contents are not cleared by reset.
- rsp_ready high in IDLE/WAIT is ignored.

## Structure
- Shared package (dmem_pkg): state enum (IDLE/WAIT/RESP), BASE_ADDR default, byte-lane count 8, latency counter width 4.
- Sub-module dmem_array: DEPTH_WORDS x 64 storage, synchronous read, per-byte write enable; no reset. FSM, counter, range check and response registers live in dmem_responder.

## Test plan
- Reset then idle: rst_n low 3 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0; after release req_ready=1 next cycle.
- sd 0x8000_0010 data 0x1122334455667788 mask 8'hFF, then ld same -> store rsp in cycle c+3 (LATENCY=2), load returns 0x1122334455667788, rsp_err=0.
- sb lane 3: addr 0x8000_0013, wdata 0x0000_0000_AB00_0000, mask 8'h08 on word above -> reload returns 0x11223344AB667788.
- Out-of-range load 0x7FFF_FFF8 and store 0x8000_2000 (DEPTH 1024) -> rsp_err=1, rdata=0, array unchanged.
- Response backpressure: rsp_ready low 5 cycles -> rsp_valid/rdata stable, req_ready=0, new req_valid not accepted until handshake.
- Reset during WAIT of a store to 0x8000_0020 -> no rsp, later load of 0x8000_0020 returns prior contents; LATENCY=0 build: rsp_valid in cycle c+1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Responder FSM: accept a request, count out the latency, present the response.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [63:0] DefaultBaseAddr = 64'h8000_0000;
  localparam int unsigned NumLanes        = 8;
  localparam int unsigned CntW            = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 64-bit storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IdxW        = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [IdxW-1:0]       idx,
  input  logic [63:0]           wdata,
  input  logic [NumLanes-1:0]   wmask,
  output logic [63:0]           rdata
);

  logic [63:0] mem [DEPTH_WORDS];
  logic [63:0] rdata_q;

  // Byte-lane writes and synchronous read; the read register holds until the next read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(NumLanes); b++) begin
        if (wmask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable response latency.
// The array access happens on the edge that enters the response state, so a store is
// committed before its response and a following load sees the new data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned      XLEN        = 64,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR   = XLEN'(DefaultBaseAddr),
  parameter int unsigned      LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [NumLanes-1:0]  req_wmask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err
);

  localparam int unsigned     IdxW       = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RangeBytes = XLEN'(DEPTH_WORDS) << 3;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wen_q, wen_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NumLanes-1:0]   wmask_q, wmask_d;
  logic                  err_q, err_d;
  logic                  ld_ok_q, ld_ok_d;
  logic                  rsp_err_q, rsp_err_d;

  // Range check by unsigned subtraction: addresses below the base wrap to huge offsets.
  logic [XLEN-1:0]       req_off;
  logic                  req_err;
  logic [IdxW-1:0]       req_idx;

  assign req_off = req_addr - BASE_ADDR;
  assign req_err = (req_off >= RangeBytes);
  assign req_idx = req_off[IdxW+2:3];

  // Access operands: straight from the request when entering RESP from IDLE (zero latency),
  // otherwise from the latched copy.
  logic                  from_idle;
  logic                  acc_wen;
  logic                  acc_err;
  logic [IdxW-1:0]       acc_idx;
  logic [XLEN-1:0]       acc_wdata;
  logic [NumLanes-1:0]   acc_wmask;
  logic                  go_resp;

  assign from_idle = (state_q == StIdle);
  assign acc_wen   = from_idle ? req_wen   : wen_q;
  assign acc_err   = from_idle ? req_err   : err_q;
  assign acc_idx   = from_idle ? req_idx   : idx_q;
  assign acc_wdata = from_idle ? req_wdata : wdata_q;
  assign acc_wmask = from_idle ? req_wmask : wmask_q;

  logic                  arr_rd_en;
  logic                  arr_wr_en;
  logic [63:0]           arr_rdata;

  assign arr_wr_en = go_resp & acc_wen & ~acc_err & (|acc_wmask);
  assign arr_rd_en = go_resp & ~acc_wen & ~acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IdxW        (IdxW)
  ) u_array (
    .clk   (clk),
    .rd_en (arr_rd_en),
    .wr_en (arr_wr_en),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .wmask (acc_wmask),
    .rdata (arr_rdata)
  );

  // Next-state, request latching and response-flag capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wen_d     = wen_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    err_d     = err_q;
    ld_ok_d   = ld_ok_q;
    rsp_err_d = rsp_err_q;
    go_resp   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          wen_d   = req_wen;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          err_d   = req_err;
          if (LATENCY == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          go_resp = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_resp) begin
      ld_ok_d   = ~acc_wen & ~acc_err;
      rsp_err_d = acc_err;
    end

    // Registered so that ready stays low throughout reset.
    ready_d = (state_d == StIdle);
  end

  // State and request registers; reset discards any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wen_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      err_q     <= 1'b0;
      ld_ok_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wen_q     <= wen_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      err_q     <= err_d;
      ld_ok_q   <= ld_ok_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = (rsp_valid && ld_ok_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a word-level
// memory model. A second instance built with zero latency covers the fast path.
module tb_dmem_responder;

  localparam int unsigned Lat   = 2;
  localparam logic [63:0] Base  = 64'h8000_0000;
  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid0 = 1'b0, rsp_ready0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [63:0] rsp_rdata0;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [int unsigned];
  logic [63:0] last_rdata;

  always #5 clk = ~clk;

  dmem_responder #(
    .XLEN        (64),
    .DEPTH_WORDS (Depth),
    .BASE_ADDR   (Base),
    .LATENCY     (Lat)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(
    .XLEN        (64),
    .DEPTH_WORDS (Depth),
    .BASE_ADDR   (Base),
    .LATENCY     (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_range(input logic [63:0] a);
    return (a >= Base) && (a < Base + 64'(Depth) * 64'd8);
  endfunction

  function automatic int unsigned widx(input logic [63:0] a);
    return 32'((a - Base) >> 3);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One request/response on the main instance, checked against the model.
  task automatic xact(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, input int stall, input logic early,
                      input logic junk, input string tag);
    logic [63:0] exp_rd;
    logic        exp_err;
    int          k;
    exp_err = !in_range(addr);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wen) begin
        if (mask != 8'h00)
          model[widx(addr)] = merge(model.exists(widx(addr)) ? model[widx(addr)] : 64'h0,
                                    wdata, mask);
      end else begin
        exp_rd = model.exists(widx(addr)) ? model[widx(addr)] : 64'h0;
      end
    end
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "/ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    @(posedge clk); #1;
    req_valid = junk;
    if (junk) begin req_wen = 1'b0; req_addr = Base; end
    rsp_ready = early;
    k = 0;
    while (!rsp_valid && k < 40) begin @(posedge clk); #1; k++; end
    check({tag, "/lat"}, 64'(k), 64'(Lat));
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
    check({tag, "/err"}, 64'(rsp_err), 64'(exp_err));
    last_rdata = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "/hold_noready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, "/post_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "/post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v, a, d;
    logic [7:0]  m;
    int          r, st;
    logic        w, e;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_rdata", rsp_rdata, 64'd0);
      check("rst_err", 64'(rsp_err), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_ready", 64'(req_ready), 64'd1);
    check("release_valid", 64'(rsp_valid), 64'd0);

    // Give a window of words and the top word known contents.
    for (int w_i = 0; w_i < 16; w_i++)
      xact(1'b1, Base + 64'(w_i) * 8, {$urandom(), $urandom()}, 8'hFF, 0, 1'b0, 1'b0, "init");
    xact(1'b1, Base + 64'h1FF8, {$urandom(), $urandom()}, 8'hFF, 0, 1'b0, 1'b0, "init_top");

    // Doubleword store then load.
    xact(1'b1, Base + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b0, 1'b0, "sd");
    xact(1'b0, Base + 64'h10, 64'h0, 8'h00, 0, 1'b0, 1'b0, "ld");
    check("ld_const", last_rdata, 64'h1122_3344_5566_7788);

    // Single byte in lane 3.
    xact(1'b1, Base + 64'h13, 64'h0000_0000_AB00_0000, 8'h08, 0, 1'b0, 1'b0, "sb");
    xact(1'b0, Base + 64'h10, 64'h0, 8'h00, 0, 1'b0, 1'b0, "ld_sb");
    check("sb_const", last_rdata, 64'h1122_3344_AB66_7788);

    // Out of range below and above; neighbouring words must be untouched.
    xact(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0, 1'b0, 1'b0, "oor_ld");
    xact(1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0, 1'b0, "oor_st");
    xact(1'b0, Base, 64'h0, 8'h00, 0, 1'b0, 1'b0, "word0");
    xact(1'b0, Base + 64'h1FF8, 64'h0, 8'h00, 0, 1'b0, 1'b0, "top");

    // Response backpressure with a competing request held valid.
    xact(1'b0, Base + 64'h10, 64'h0, 8'h00, 5, 1'b0, 1'b1, "bp");

    // rsp_ready already high while waiting.
    xact(1'b0, Base + 64'h18, 64'h0, 8'h00, 0, 1'b1, 1'b0, "early");

    // Reset during the wait of a store: the store must be lost.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = Base + 64'h20;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_wmask = 8'hFF;
    check("rw_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_wait_valid", 64'(rsp_valid), 64'd0);
    check("rw_wait_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rw_rst_valid", 64'(rsp_valid), 64'd0);
      check("rw_rst_ready", 64'(req_ready), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rw_release_ready", 64'(req_ready), 64'd1);
    check("rw_release_valid", 64'(rsp_valid), 64'd0);
    xact(1'b0, Base + 64'h20, 64'h0, 8'h00, 0, 1'b0, 1'b0, "rw_reload");

    // Zero-latency instance: response in the cycle after accept.
    v = {$urandom(), $urandom()};
    req_valid0 = 1'b1; req_wen = 1'b1; req_addr = Base + 64'h8; req_wdata = v;
    req_wmask = 8'hFF;
    check("l0_ready", 64'(req_ready0), 64'd1);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("l0_st_valid", 64'(rsp_valid0), 64'd1);
    check("l0_st_rdata", rsp_rdata0, 64'd0);
    check("l0_st_err", 64'(rsp_err0), 64'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check("l0_st_done", 64'(rsp_valid0), 64'd0);
    req_valid0 = 1'b1; req_wen = 1'b0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("l0_ld_valid", 64'(rsp_valid0), 64'd1);
    check("l0_ld_rdata", rsp_rdata0, v);
    check("l0_ld_err", 64'(rsp_err0), 64'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check("l0_ld_done", 64'(rsp_valid0), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = Base - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
      else if (r == 1) a = Base + 64'(Depth) * 8 + 64'($urandom_range(0, 63));
      else if (r == 2) a = Base + 64'h1FF8 + 64'($urandom_range(0, 7));
      else             a = Base + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      d  = {$urandom(), $urandom()};
      m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      st = int'($urandom_range(0, 3));
      e  = (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      xact(w, a, d, m, st, e, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
